udma_ext_tx_arbiter: RTL



---
 rtl/udma_pkg.sv | 32 +++
 rtl/udma_arb_fifo.sv | 44 ++++
 rtl/udma_ext_tx_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/udma_pkg.sv
// Shared uDMA channel types, datasize codes and the response alignment helper.
package udma_pkg;

  typedef logic [31:0] ch_addr_t;
  typedef logic [31:0] ch_data_t;
  typedef logic [1:0]  ch_datasize_t;
  typedef logic [3:0]  ch_id_t;

  localparam ch_datasize_t UDMA_SIZE_BYTE = 2'd0;
  localparam ch_datasize_t UDMA_SIZE_HALF = 2'd1;
  localparam ch_datasize_t UDMA_SIZE_WORD = 2'd2;

  // Everything needed to route and align one read response.
  typedef struct packed {
    ch_id_t       id;
    ch_datasize_t size;
    logic [1:0]   off;
  } arb_tag_t;

  // Zero-extended byte/half extraction; size 3 falls through to word.
  function automatic ch_data_t udma_align(input ch_data_t data, input ch_datasize_t size,
                                          input logic [1:0] off);
    ch_data_t result;
    case (size)
      UDMA_SIZE_BYTE: result = {24'h0, 8'(data >> {off, 3'b000})};
      UDMA_SIZE_HALF: result = {16'h0, 16'(data >> {off[1], 4'b0000})};
      default:        result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/udma_arb_fifo.sv
// Small synchronous FIFO used for the arbiter's tag and read-data queues.
module udma_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = store[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      store[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/udma_ext_tx_arbiter.sv
// Round-robin N-channel read arbiter onto one L2 read port with in-order, aligned responses.
// Optional high-priority request class enabled by defining UDMA_EXT_ARB_PRIO_EN.
module udma_ext_tx_arbiter
  import udma_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          ch_req_i,
`ifdef UDMA_EXT_ARB_PRIO_EN
  input  logic [N_CH-1:0]          prio_i,
`endif
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [N_CH*2-1:0]        ch_datasize_i,
  output logic [N_CH-1:0]          ch_gnt_o,
  output logic [N_CH-1:0]          ch_valid_o,
  output logic [DATA_W-1:0]        ch_data_o,
  input  logic [N_CH-1:0]          ch_ready_i,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic [$clog2(DEPTH):0]   outstanding_o
);

  localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int TW  = $bits(arb_tag_t);

  // Handshakes: a request is issued when mem_req_o && mem_gnt_i; a response is
  // delivered when ch_valid_o[k] && ch_ready_i[k]. Valid never waits on ready.

  logic [IDW-1:0]    rr;
  logic [IDW-1:0]    winner;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     mask_cnt;
  logic [N_CH-1:0]   search;
  logic              issue;
  logic              deliver;
  logic              resp_valid;
  logic              sel_ready;
  logic [ADDR_W-1:0] win_addr;
  ch_datasize_t      win_size;
  arb_tag_t          push_tag;
  arb_tag_t          head_tag;
  logic [TW-1:0]     tag_rdata;
  logic [DATA_W-1:0] head_data;
  logic              tag_empty;
  logic              tag_full;
  logic              data_empty;
  logic              data_full;

  // First requester at or after start, by wrap-around distance.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_CH-1:0] reqs,
                                             input logic [IDW-1:0] start);
    logic [IDW-1:0] pick;
    int best_d;
    int d;
    pick   = start;
    best_d = N_CH;
    for (int j = 0; j < N_CH; j++) begin
      if (reqs[j]) begin
        d = j - int'(start);
        if (d < 0) d = d + N_CH;
        if (d < best_d) begin
          best_d = d;
          pick   = IDW'(j);
        end
      end
    end
    return pick;
  endfunction

  always_comb begin
`ifdef UDMA_EXT_ARB_PRIO_EN
    search = (|(ch_req_i & prio_i)) ? (ch_req_i & prio_i) : ch_req_i;
`else
    search = ch_req_i;
`endif
  end

  assign winner    = rr_pick(search, rr);
  assign mem_req_o = (|ch_req_i) && (cnt < CW'(DEPTH));
  assign issue     = mem_req_o && mem_gnt_i;

  always_comb begin
    win_addr = ch_addr_i[ADDR_W-1:0];
    win_size = ch_datasize_i[1:0];
    ch_gnt_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (winner == IDW'(k)) begin
        win_addr    = ch_addr_i[k*ADDR_W +: ADDR_W];
        win_size    = ch_datasize_i[k*2 +: 2];
        ch_gnt_o[k] = issue;
      end
    end
  end

  assign mem_addr_o = {win_addr[ADDR_W-1:2], 2'b00};
  assign push_tag   = '{id: ch_id_t'(winner), size: win_size, off: win_addr[1:0]};

  udma_arb_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (issue && !tag_full),
    .wdata (push_tag),
    .pop   (deliver),
    .rdata (tag_rdata),
    .empty (tag_empty),
    .full  (tag_full)
  );

  // Read data without a tag (e.g. left over from before reset) is dropped.
  udma_arb_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (mem_rvalid_i && !tag_empty && !data_full),
    .wdata (mem_rdata_i),
    .pop   (deliver),
    .rdata (head_data),
    .empty (data_empty),
    .full  (data_full)
  );

  assign head_tag   = arb_tag_t'(tag_rdata);
  assign resp_valid = !tag_empty && !data_empty;

  always_comb begin
    ch_valid_o = '0;
    sel_ready  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (head_tag.id == ch_id_t'(k)) begin
        ch_valid_o[k] = resp_valid;
        sel_ready     = ch_ready_i[k];
      end
    end
  end

  assign deliver       = resp_valid && sel_ready;
  assign ch_data_o     = resp_valid ? udma_align(head_data, head_tag.size, head_tag.off) : '0;
  assign outstanding_o = cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      rr       <= '0;
      mask_cnt <= CW'(DEPTH);
    end else begin
      case ({issue, deliver})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (issue)
        rr <= (winner == IDW'(N_CH-1)) ? '0 : winner + IDW'(1);
      if (mask_cnt != '0)
        mask_cnt <= mask_cnt - CW'(1);
    end
  end

  // Read data with no tag in flight is a memory-side protocol error.
  a_rvalid_has_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_rvalid_i && tag_empty && (mask_cnt == '0)));

endmodule
